stack_shift_ctrl: RTL and testbench
===================================

Name: stack_shift_ctrl

Overview:
- Sequencer for a bit-serial stack built from one shift register of WIDTH*DEPTH bits; the top of stack is held in the low WIDTH bits.
- Accepts PUSH, POP and CLEAR commands over a valid/ready handshake.
- Drives the shift register's d, en, dir and synchronous-clear inputs.
- Tracks stack depth and returns popped words plus an error flag on a one-cycle response strobe.

Parameters:
- WIDTH, 8: bits per stack entry; sets the shift count per operation.
- DEPTH, 4: number of stack entries; the attached shift register is WIDTH*DEPTH bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  2  00 PUSH, 01 POP, 10 CLEAR, 11 reserved
- cmd_data  in  WIDTH  word to push
- rsp_valid  out  1  one-cycle completion strobe
- rsp_data  out  WIDTH  last successfully popped word
- rsp_err  out  1  error flag, valid when rsp_valid=1
- sr_d  out  1  serial data to the shift register
- sr_en  out  1  shift enable
- sr_dir  out  1  0 = shift toward MSB (push), 1 = shift toward LSB (pop)
- sr_clr  out  1  synchronous clear to the shift register
- sr_lsb  in  1  shift register bit 0, sampled before each shift
- depth  out  clog2(DEPTH+1)  current entry count
- full  out  1  depth == DEPTH
- empty  out  1  depth == 0

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, depth=0, rsp_valid=0, rsp_err=0, rsp_data=0.
  - Bit counter and shift buffer cleared.
  - sr_en=0, sr_clr=0, sr_d=0, sr_dir=0, so cmd_ready=1 after release.
  - Stale shift-register contents are unreachable because depth=0.
- States: IDLE, SHIFT, CLR, DONE.
- cmd_ready=1 only in IDLE. A command is accepted in cycle T when cmd_valid && cmd_ready; op and data are latched.
- Transitions from IDLE on accept:
  - PUSH with full=1 -> DONE with err.
  - POP with empty=1 -> DONE with err.
  - Op 11 -> DONE with err.
  - CLEAR -> CLR.
  - Valid PUSH/POP -> SHIFT with bit counter = WIDTH-1.
- SHIFT lasts WIDTH cycles (T+1..T+WIDTH), with sr_en=1 every cycle.
  - PUSH: sr_dir=0, sr_d = latched word MSB first (bit WIDTH-1 at T+1, bit 0 at T+WIDTH). After WIDTH shifts the low WIDTH bits equal the word.
  - POP: sr_dir=1, sr_d=0. Each cycle sr_lsb is shifted into the buffer from the top (buf <= {sr_lsb, buf[WIDTH-1:1]}), so the word is rebuilt LSB first.
  - On the counter-zero cycle the block moves to DONE.
- CLR lasts one cycle: sr_clr=1, sr_en=0, then DONE.
- DONE lasts one cycle: rsp_valid=1, then IDLE.
  - Success: PUSH depth+1; POP depth-1 and rsp_data <= buffer; CLEAR depth=0.
  - Error: depth, rsp_data and the shift register are unchanged; rsp_err=1.
- Latency:
  - PUSH/POP: rsp_valid at T+WIDTH+1, cmd_ready again at T+WIDTH+2.
  - CLEAR: rsp_valid at T+2.
  - Error: rsp_valid at T+1.
- rsp_err is 0 whenever rsp_valid=0. rsp_data holds its value except on a successful POP.
- sr_en and sr_clr are never high together. Outside SHIFT: sr_en=0 and sr_d=0.
- Commands presented while cmd_ready=0 are ignored; the requester must hold them until accepted.
- depth never exceeds DEPTH and never underflows.
- Reset asserted mid-SHIFT: outputs drop immediately and the partial shift is abandoned. The bench must also reset the shift register.

Test Plan:
- Reset, then PUSH 0xA5 (WIDTH=8) -> sr_d sequence 1,0,1,0,0,1,0,1 over 8 cycles with sr_en=1, sr_dir=0; rsp_valid at T+9 with rsp_err=0; depth=1; cmd_ready back at T+10.
- PUSH 0x12, PUSH 0x34, POP, POP -> rsp_data 0x34 then 0x12; depth 2,1,0; empty=1 at end.
- POP on empty -> rsp_valid at T+1 with rsp_err=1; sr_en never asserted; depth stays 0.
- PUSH 4 words (DEPTH=4), then PUSH 0xFF -> full=1; 5th response rsp_err=1; depth stays 4; subsequent POP returns the 4th word.
- PUSH 0x77, CLEAR -> sr_clr high exactly one cycle at T+1; rsp_valid at T+2, rsp_err=0; depth=0; next POP errors.
- Assert rst_n low at the 4th cycle of a PUSH -> sr_en=0 and rsp_valid=0 immediately; depth=0 and cmd_ready=1 after release; op 11 afterwards -> rsp_err=1.

Source files
------------

// File: rtl/stack_shift_ctrl.sv
// stack_shift_ctrl
//   Sequencer for a bit-serial stack held in an external WIDTH*DEPTH-bit
//   shift register whose low WIDTH bits are the top of stack.
//   PUSH shifts a word in MSB first toward the register MSB. POP shifts the
//   register toward the LSB and rebuilds the top word from sr_lsb, LSB first.
//   CLEAR pulses the register's synchronous clear.
//
// Ports
//   clk, rst_n             clock, async active-low reset
//   cmd_valid/ready        command handshake; cmd_op 00 PUSH 01 POP 10 CLEAR
//   cmd_op, cmd_data       operation and word to push
//   rsp_valid              one-cycle completion strobe
//   rsp_data               last successfully popped word
//   rsp_err                error flag, qualified by rsp_valid
//   sr_d/en/dir/clr        shift register controls (dir 0 = toward MSB)
//   sr_lsb                 shift register bit 0
//   depth, full, empty     occupancy
module stack_shift_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int DW   = $clog2(DEPTH + 1),
  localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             sr_d,
  output logic             sr_en,
  output logic             sr_dir,
  output logic             sr_clr,
  input  logic             sr_lsb,
  output logic [DW-1:0]    depth,
  output logic             full,
  output logic             empty
);

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_CLR  = 2'b10,
    OP_RSV  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    CLR   = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t           state, nxt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] buf_q;
  logic [CW-1:0]    cnt;
  logic             err_q;
  logic             accept;
  logic             bad;
  logic [WIDTH-1:0] buf_nxt;

  assign full    = (depth == DW'(DEPTH));
  assign empty   = (depth == '0);
  assign accept  = cmd_valid && cmd_ready;
  assign buf_nxt = {sr_lsb, buf_q[WIDTH-1:1]};

  // Rejected commands go straight to DONE and never touch the register.
  assign bad = ((cmd_op == OP_PUSH) && full)  ||
               ((cmd_op == OP_POP)  && empty) ||
               (cmd_op == OP_RSV);

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (bad)                 nxt = DONE;
          else if (cmd_op == OP_CLR) nxt = CLR;
          else                     nxt = SHIFT;
        end
      end
      SHIFT: if (cnt == '0) nxt = DONE;
      CLR:   nxt = DONE;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs decode straight from state so an async reset drops them at once.
  always_comb begin
    cmd_ready = (state == IDLE);
    sr_en     = (state == SHIFT);
    sr_dir    = (state == SHIFT) && (op_q == OP_POP);
    sr_d      = (state == SHIFT) && (op_q == OP_PUSH) && word_q[cnt];
    sr_clr    = (state == CLR);
    rsp_valid = (state == DONE);
    rsp_err   = (state == DONE) && err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      word_q   <= '0;
      buf_q    <= '0;
      cnt      <= '0;
      err_q    <= 1'b0;
      depth    <= '0;
      rsp_data <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q   <= cmd_op;
          word_q <= cmd_data;
          err_q  <= bad;
          cnt    <= CW'(WIDTH - 1);
          buf_q  <= '0;
        end
        SHIFT: begin
          if (op_q == OP_POP) buf_q <= buf_nxt;
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            // Commit on the last shift so depth and rsp_data are already
            // current while rsp_valid is high.
            if (op_q == OP_POP) begin
              rsp_data <= buf_nxt;
              depth    <= depth - 1'b1;
            end else begin
              depth    <= depth + 1'b1;
            end
          end
        end
        CLR: depth <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_shift_ctrl.sv
// tb_stack_shift_ctrl
//   Directed bench for stack_shift_ctrl (WIDTH=8, DEPTH=4) with a behavioural
//   WIDTH*DEPTH-bit shift register attached to the sr_* pins.
module tb_stack_shift_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int N     = WIDTH * DEPTH;
  localparam int DW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [WIDTH-1:0] cmd_data = '0;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;
  logic             sr_d, sr_en, sr_dir, sr_clr, sr_lsb;
  logic [DW-1:0]    depth;
  logic             full, empty;

  logic [N-1:0]     sr;

  int n_cmp = 0;
  int n_bad = 0;

  // results of the last run_cmd
  int         lat, en_cnt, clr_cnt, clr_at, both, errlow, dstray;
  logic [7:0] dseq, r_data;
  logic       r_err, dir_or, dir_and, rdy_after, vld_after;
  bit         got;

  stack_shift_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .sr_d(sr_d), .sr_en(sr_en), .sr_dir(sr_dir), .sr_clr(sr_clr),
    .sr_lsb(sr_lsb),
    .depth(depth), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      sr <= '0;
    else if (sr_clr) sr <= '0;
    else if (sr_en)  sr <= sr_dir ? {1'b0, sr[N-1:1]} : {sr[N-2:0], sr_d};
  end
  assign sr_lsb = sr[0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one command and watch every cycle until its response strobe.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] data);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    @(negedge clk);
    chk("accept_ready", 32'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0; en_cnt = 0; clr_cnt = 0; clr_at = 0; both = 0; errlow = 0;
    dstray = 0; dseq = '0; r_data = '0; r_err = 1'b0;
    dir_or = 1'b0; dir_and = 1'b1; got = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (sr_en) begin
        en_cnt++;
        dseq    = {dseq[6:0], sr_d};
        dir_or  = dir_or | sr_dir;
        dir_and = dir_and & sr_dir;
      end else if (sr_d) dstray++;
      if (sr_clr) begin clr_cnt++; clr_at = k; end
      if (sr_en && sr_clr) both++;
      if (!rsp_valid && rsp_err) errlow++;
      if (rsp_valid) begin
        got = 1; lat = k; r_err = rsp_err; r_data = rsp_data;
      end
    end
    if (!got) chk("rsp_timeout", 0, 1);
    @(negedge clk);
    rdy_after = cmd_ready;
    vld_after = rsp_valid;
    chk("ready_after", 32'(rdy_after), 1);
    chk("strobe_1cyc", 32'(vld_after), 0);
    chk("no_en_clr", 32'(both), 0);
    chk("err_qual", 32'(errlow), 0);
    chk("sr_d_idle", 32'(dstray), 0);
  endtask

  task automatic push_ok(input logic [7:0] w, input int exp_depth);
    run_cmd(2'b00, w);
    chk("push_lat", 32'(lat), 9);
    chk("push_err", 32'(r_err), 0);
    chk("push_en", 32'(en_cnt), 8);
    chk("push_dseq", 32'(dseq), 32'(w));
    chk("push_dir", 32'(dir_or), 0);
    chk("push_depth", 32'(depth), 32'(exp_depth));
  endtask

  task automatic pop_ok(input logic [7:0] w, input int exp_depth);
    run_cmd(2'b01, 8'h00);
    chk("pop_lat", 32'(lat), 9);
    chk("pop_err", 32'(r_err), 0);
    chk("pop_en", 32'(en_cnt), 8);
    chk("pop_dir", 32'(dir_and), 1);
    chk("pop_d", 32'(dseq), 0);
    chk("pop_data", 32'(r_data), 32'(w));
    chk("pop_depth", 32'(depth), 32'(exp_depth));
  endtask

  task automatic cmd_err(input logic [1:0] op, input logic [7:0] w,
                         input int exp_depth, input logic [7:0] exp_data);
    run_cmd(op, w);
    chk("err_lat", 32'(lat), 1);
    chk("err_flag", 32'(r_err), 1);
    chk("err_no_en", 32'(en_cnt), 0);
    chk("err_no_clr", 32'(clr_cnt), 0);
    chk("err_depth", 32'(depth), 32'(exp_depth));
    chk("err_data", 32'(r_data), 32'(exp_data));
  endtask

  initial begin
    // reset state
    #12;
    @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_depth", 32'(depth), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_vld", 32'(rsp_valid), 0);
    chk("rst_en", 32'(sr_en), 0);
    chk("rst_data", 32'(rsp_data), 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // single push: sr_d 1,0,1,0,0,1,0,1 then pop it back
    push_ok(8'hA5, 1);
    chk("a5_empty", 32'(empty), 0);
    pop_ok(8'hA5, 0);

    // LIFO order
    push_ok(8'h12, 1);
    push_ok(8'h34, 2);
    pop_ok(8'h34, 1);
    pop_ok(8'h12, 0);
    chk("lifo_empty", 32'(empty), 1);

    // pop on empty; rsp_data keeps last popped word
    cmd_err(2'b01, 8'h00, 0, 8'h12);

    // fill, overflow, then pop the 4th word
    push_ok(8'h01, 1);
    push_ok(8'h02, 2);
    push_ok(8'h03, 3);
    push_ok(8'h04, 4);
    chk("fill_full", 32'(full), 1);
    cmd_err(2'b00, 8'hFF, 4, 8'h12);
    pop_ok(8'h04, 3);
    chk("after_full", 32'(full), 0);

    // clear
    push_ok(8'h77, 4);
    run_cmd(2'b10, 8'h00);
    chk("clr_lat", 32'(lat), 2);
    chk("clr_err", 32'(r_err), 0);
    chk("clr_cnt", 32'(clr_cnt), 1);
    chk("clr_at", 32'(clr_at), 1);
    chk("clr_en", 32'(en_cnt), 0);
    chk("clr_depth", 32'(depth), 0);
    cmd_err(2'b01, 8'h00, 0, 8'h04);

    // reset during the 4th shift cycle of a push
    push_ok(8'h55, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 8'hC3;
    @(negedge clk);
    chk("mid_accept", 32'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_shifting", 32'(sr_en), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_en", 32'(sr_en), 0);
    chk("mid_rst_vld", 32'(rsp_valid), 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("mid_depth", 32'(depth), 0);
    chk("mid_ready", 32'(cmd_ready), 1);
    cmd_err(2'b11, 8'h00, 0, 8'h00);

    // empty again after reset: push/pop still works
    push_ok(8'h3C, 1);
    pop_ok(8'h3C, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
